gmii_tx_sched: RTL

Frame scheduler in front of the GMII transmit pins. It shares one GMII TX port between NUM_SRC byte-stream frame sources using round-robin arbitration. For each granted frame it inserts the preamble and SFD, streams the source bytes (FCS is supplied by the source) and enforces the inter-frame gap. It runs in the 125 MHz transmit domain generated by the PLL and replaces direct source-to-pin driving of txd, tx_en and tx_er.

---
 rtl/gmii_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/gmii_tx_sched.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/gmii_pkg.sv
// Shared GMII transmit constants, scheduler state encoding and helpers.
package gmii_pkg;

   localparam logic [7:0]  GMII_PRE = 8'h55;
   localparam logic [7:0]  GMII_SFD = 8'hD5;
   localparam int unsigned CNT_W    = 11;

   typedef enum logic [2:0] {
      IDLE,
      PRE,
      SFD,
      DATA,
      ABORT,
      IFG
   } tx_state_t;

   // Index of the set bit in a one-hot vector of up to 8 bits; 0 when none set.
   function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
      onehot_idx = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (oh[i]) onehot_idx = 3'(i);
      end
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among requesters, starting at a registered pointer that
// moves to one past the finishing source when ptr_upd is pulsed.
module rr_arbiter
   import gmii_pkg::*;
#(
   parameter int unsigned NUM_SRC = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_SRC-1:0] req,
   input  logic               ptr_upd,
   input  logic [NUM_SRC-1:0] cur_gnt,
   output logic [NUM_SRC-1:0] gnt
);

   localparam int unsigned PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] idx;
   logic [2:0]    cur_idx;
   logic          found;

   assign cur_idx = onehot_idx(8'(cur_gnt));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else if (ptr_upd) begin
         ptr_q <= (cur_idx == 3'(NUM_SRC - 1)) ? '0 : PW'(cur_idx + 3'd1);
      end
   end

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         idx = PW'((32'(ptr_q) + i) % NUM_SRC);
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/gmii_tx_sched.sv
// GMII TX frame scheduler: round-robin shares one GMII port among NUM_SRC
// byte-stream sources, adding preamble/SFD and enforcing the inter-frame gap.
module gmii_tx_sched
   import gmii_pkg::*;
#(
   parameter int unsigned NUM_SRC   = 2,
   parameter int unsigned PRE_BYTES = 7,
   parameter int unsigned IFG_BYTES = 12,
   parameter int unsigned MAX_FRAME = 1522
) (
   input  logic                 clk_125m,
   input  logic                 rst_n,
   input  logic [NUM_SRC-1:0]   req,
   output logic [NUM_SRC-1:0]   gnt,
   input  logic [NUM_SRC*8-1:0] din,
   input  logic [NUM_SRC-1:0]   din_vld,
   input  logic [NUM_SRC-1:0]   din_last,
   output logic [NUM_SRC-1:0]   din_ack,
   output logic [7:0]           txd,
   output logic                 tx_en,
   output logic                 tx_er,
   output logic                 tx_abort
);

   tx_state_t          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
   logic [7:0]         txd_d;
   logic               tx_en_d, tx_er_d, abort_d;
   logic [NUM_SRC-1:0] gnt_d, pick;
   logic               ptr_upd;
   logic [7:0]         g_byte;
   logic               g_vld, g_last;

   rr_arbiter #(
      .NUM_SRC (NUM_SRC)
   ) u_arb (
      .clk     (clk_125m),
      .rst_n   (rst_n),
      .req     (req),
      .ptr_upd (ptr_upd),
      .cur_gnt (gnt),
      .gnt     (pick)
   );

   always_comb begin
      g_byte = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (gnt[i]) g_byte = din[8*i +: 8];
      end
   end

   assign g_vld   = |(din_vld & gnt);
   assign g_last  = |(din_last & gnt);
   assign din_ack = (state_q == SFD || state_q == DATA) ? gnt : '0;
   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

   // Outputs are computed for the next cycle and registered, so each state
   // decides what txd/tx_en show one cycle later.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      txd_d   = '0;
      tx_en_d = 1'b0;
      tx_er_d = 1'b0;
      abort_d = 1'b0;
      gnt_d   = gnt;
      ptr_upd = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = PRE;
               cnt_d   = '0;
               txd_d   = GMII_PRE;
               tx_en_d = 1'b1;
               gnt_d   = pick;
            end
         end
         PRE: begin
            tx_en_d = 1'b1;
            if (cnt_q == CNT_W'(PRE_BYTES - 1)) begin
               state_d = SFD;
               cnt_d   = '0;
               txd_d   = GMII_SFD;
            end else begin
               cnt_d = cnt_inc;
               txd_d = GMII_PRE;
            end
         end
         SFD, DATA: begin
            if (!g_vld || (!g_last && cnt_q == CNT_W'(MAX_FRAME - 1))) begin
               state_d = ABORT;
               tx_en_d = 1'b1;
               tx_er_d = 1'b1;
               abort_d = 1'b1;
               gnt_d   = '0;
               ptr_upd = 1'b1;
            end else if (g_last) begin
               state_d = IFG;
               cnt_d   = '0;
               txd_d   = g_byte;
               tx_en_d = 1'b1;
               ptr_upd = 1'b1;
            end else begin
               state_d = DATA;
               cnt_d   = cnt_inc;
               txd_d   = g_byte;
               tx_en_d = 1'b1;
            end
         end
         ABORT: begin
            // Abort cycle already is the last tx_en cycle, so the gap count starts at 1.
            state_d = IFG;
            cnt_d   = CNT_W'(1);
            gnt_d   = '0;
         end
         IFG: begin
            gnt_d = '0;
            if (cnt_q == CNT_W'(IFG_BYTES)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_125m or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         txd      <= '0;
         tx_en    <= 1'b0;
         tx_er    <= 1'b0;
         tx_abort <= 1'b0;
         gnt      <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         txd      <= txd_d;
         tx_en    <= tx_en_d;
         tx_er    <= tx_er_d;
         tx_abort <= abort_d;
         gnt      <= gnt_d;
      end
   end

endmodule
